// File: rtl/quad_enc_pkg.sv
// Shared types for the quadrature step generator: FSM states, Gray phase codes
// and the single-step phase advance used by the phase sequencer.
package quad_enc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Phase codes are {A,B}
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic up);
    logic [1:0] nxt;
    nxt = PH_00;
    case (ph)
      PH_00:   nxt = up ? PH_10 : PH_01;
      PH_10:   nxt = up ? PH_11 : PH_00;
      PH_11:   nxt = up ? PH_01 : PH_10;
      PH_01:   nxt = up ? PH_00 : PH_11;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_phase_seq.sv
// Two-bit Gray phase stepper: advances one quadrature position per step pulse.
// Registered outputs, one-cycle update latency; step is never refused.
module quad_phase_seq
  import quad_enc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic step,
  input  logic up,
  output logic a,
  output logic b
);

  logic [1:0] ph_q;
  logic [1:0] ph_d;

  always_comb begin
    ph_d = ph_q;
    if (step) begin
      ph_d = next_phase(ph_q, up);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ph_q <= PH_00;
    end else begin
      ph_q <= ph_d;
    end
  end

  assign a = ph_q[1];
  assign b = ph_q[0];

endmodule

// File: rtl/quad_enc_gen.sv
// Quadrature step generator: walks pos toward a latched target, one Gray step every P clocks.
// First step lands P edges after start; hold freezes the step timer, start/load are ignored while busy.
module quad_enc_gen
  import quad_enc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic [DIV_W-1:0] period,
  input  logic             hold,
  output logic             phase_a,
  output logic             phase_b,
  output logic [WIDTH-1:0] pos,
  output logic             up_dn,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] timer_q, timer_d;
  logic [DIV_W-1:0] per_q,   per_d;
  logic [WIDTH-1:0] tgt_q,   tgt_d;
  logic [WIDTH-1:0] pos_q,   pos_d;
  logic             up_q,    up_d;
  logic             step;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    per_d   = per_q;
    tgt_d   = tgt_q;
    pos_d   = pos_q;
    up_d    = up_q;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!load) begin
          pos_d = data;
        end else if (start) begin
          if (target != pos_q) begin
            tgt_d   = target;
            per_d   = (period == '0) ? DIV_W'(1) : period;
            up_d    = (target > pos_q);
            timer_d = '0;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (!hold) begin
          if (timer_q == per_q - DIV_W'(1)) begin
            step    = 1'b1;
            timer_d = '0;
            pos_d   = up_q ? pos_q + WIDTH'(1) : pos_q - WIDTH'(1);
            if (pos_d == tgt_q) begin
              state_d = DONE;
            end
          end else begin
            timer_d = timer_q + DIV_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      per_q   <= DIV_W'(1);
      tgt_q   <= '0;
      pos_q   <= '0;
      up_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      per_q   <= per_d;
      tgt_q   <= tgt_d;
      pos_q   <= pos_d;
      up_q    <= up_d;
    end
  end

  // The phase pair only moves on steps, so a preset of pos leaves it where it was
  quad_phase_seq u_phase (
    .clk   (clk),
    .reset (reset),
    .step  (step),
    .up    (up_q),
    .a     (phase_a),
    .b     (phase_b)
  );

  assign pos   = pos_q;
  assign up_dn = up_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_quad_enc_gen.sv
// Bench for quad_enc_gen: directed and random moves checked every cycle against an elapsed-time model.
module tb_quad_enc_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] data;
  logic       start;
  logic [7:0] target;
  logic [7:0] period;
  logic       hold;
  logic       phase_a;
  logic       phase_b;
  logic [7:0] pos;
  logic       up_dn;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  // Reference state: position, index into the up-order phase table, last direction
  logic [7:0] m_pos;
  int         m_ph;
  logic       m_up;
  logic [1:0] ph_tab [4];

  always #5 clk = ~clk;

  quad_enc_gen #(.WIDTH(8), .DIV_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .data    (data),
    .start   (start),
    .target  (target),
    .period  (period),
    .hold    (hold),
    .phase_a (phase_a),
    .phase_b (phase_b),
    .pos     (pos),
    .up_dn   (up_dn),
    .busy    (busy),
    .done    (done)
  );

  // Runs one move from the model position; hs/hl place a hold window (edge offsets from start),
  // poke drives a load and a competing start while busy, which must both be ignored.
  task automatic move(input logic [7:0] tgt, input logic [7:0] per, input int hs, input int hl,
                      input bit poke, input string nm);
    int         p, d, dp, eff, steps, idx;
    logic       up, done_seen, finished;
    logic       exp_busy, exp_done;
    logic [7:0] exp_pos;
    p  = (per == 8'd0) ? 1 : int'(per);
    up = (tgt == m_pos) ? m_up : (tgt > m_pos);
    d  = up ? int'(tgt) - int'(m_pos) : int'(m_pos) - int'(tgt);
    dp = d * p;
    eff = 0;
    idx = m_ph;
    done_seen = 1'b0;
    finished  = 1'b0;
    start = 1'b1; target = tgt; period = per;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      steps    = eff / p;
      exp_busy = (eff < dp);
      exp_done = (eff == dp) && !done_seen;
      exp_pos  = up ? m_pos + 8'(steps) : m_pos - 8'(steps);
      idx      = up ? (m_ph + steps) % 4 : (((m_ph - steps) % 4) + 4) % 4;
      checks++;
      if ({busy, done, up_dn, pos, phase_a, phase_b} !==
          {exp_busy, exp_done, up, exp_pos, ph_tab[idx]}) begin
        errors++;
        $display("FAIL %s t=%0d got busy=%b done=%b up_dn=%b pos=%0d ab=%b%b, want busy=%b done=%b up_dn=%b pos=%0d ab=%b",
                 nm, t, busy, done, up_dn, pos, phase_a, phase_b,
                 exp_busy, exp_done, up, exp_pos, ph_tab[idx]);
      end
      if (done_seen) begin
        finished = 1'b1;
        break;
      end
      if (exp_done) done_seen = 1'b1;
      hold = (t + 1 >= hs) && (t + 1 < hs + hl);
      if (poke && t == 1) begin
        load = 1'b0; data = 8'($urandom); start = 1'b1; target = 8'($urandom);
      end else begin
        load = 1'b1; start = 1'b0;
      end
      @(posedge clk);
      if (eff < dp && !hold) eff++;
      @(negedge clk);
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout got finished=%b want 1", nm, finished);
    end
    hold = 1'b0; load = 1'b1; start = 1'b0;
    m_pos = tgt;
    m_ph  = idx;
    m_up  = up;
  endtask

  task automatic preset(input logic [7:0] v, input string nm);
    load = 1'b0; data = v; start = 1'b1; target = v + 8'd3;
    @(posedge clk);
    @(negedge clk);
    load = 1'b1; start = 1'b0;
    m_pos = v;
    checks++;
    if ({busy, done, pos, phase_a, phase_b} !== {1'b0, 1'b0, v, ph_tab[m_ph]}) begin
      errors++;
      $display("FAIL %s got busy=%b done=%b pos=%0d ab=%b%b, want busy=0 done=0 pos=%0d ab=%b",
               nm, busy, done, pos, phase_a, phase_b, v, ph_tab[m_ph]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, up_dn, pos, phase_a, phase_b} !== {1'b0, 1'b0, 1'b1, 8'd0, 2'b00}) begin
        errors++;
        $display("FAIL reset cyc=%0d got busy=%b done=%b up_dn=%b pos=%0d ab=%b%b, want 0 0 1 0 00",
                 i, busy, done, up_dn, pos, phase_a, phase_b);
      end
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, pos, phase_a, phase_b} !== {1'b0, 1'b0, 8'd0, 2'b00}) begin
      errors++;
      $display("FAIL reset_release got busy=%b done=%b pos=%0d ab=%b%b, want 0 0 0 00",
               busy, done, pos, phase_a, phase_b);
    end
    m_pos = 8'd0; m_ph = 0; m_up = 1'b1;
  endtask

  task automatic test_preset();
    preset(8'd5, "preset5");
  endtask

  task automatic test_up_move();
    move(8'd8, 8'd2, 0, 0, 1'b0, "up_move");
  endtask

  task automatic test_down_move();
    move(8'd6, 8'd0, 0, 0, 1'b0, "down_move");
  endtask

  task automatic test_zero_and_ignored();
    move(m_pos, 8'd5, 0, 0, 1'b0, "zero_dist");
    move(m_pos + 8'd4, 8'd2, 0, 0, 1'b1, "ignored_inputs");
  endtask

  task automatic test_hold();
    move(m_pos + 8'd2, 8'd3, 2, 4, 1'b0, "hold_freeze");
    move(m_pos - 8'd2, 8'd1, 1, 3, 1'b0, "hold_p1");
  endtask

  task automatic test_back_to_back();
    move(m_pos + 8'd1, 8'd1, 0, 0, 1'b0, "b2b_a");
    move(m_pos - 8'd3, 8'd1, 0, 0, 1'b0, "b2b_b");
    move(m_pos, 8'd1, 0, 0, 1'b0, "b2b_zero");
    move(m_pos + 8'd2, 8'd2, 0, 0, 1'b0, "b2b_c");
  endtask

  task automatic test_random();
    logic [7:0] base, tg, per;
    int off;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        base = 8'($urandom_range(20, 235));
        preset(base, "rand_preset");
      end
      off = $urandom_range(0, 12) - 6;
      tg  = 8'(int'(m_pos) + off);
      per = 8'($urandom_range(0, 3));
      move(tg, per, $urandom_range(1, 6), $urandom_range(0, 3), 1'b0, "rand_move");
    end
  endtask

  task automatic test_reset_mid_move();
    preset(8'd20, "pre_abort");
    start = 1'b1; target = 8'd25; period = 8'd2;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if ({busy, pos, phase_a, phase_b} !== {1'b1, 8'd22, ph_tab[(m_ph + 2) % 4]}) begin
      errors++;
      $display("FAIL abort_progress got busy=%b pos=%0d ab=%b%b, want busy=1 pos=22 ab=%b",
               busy, pos, phase_a, phase_b, ph_tab[(m_ph + 2) % 4]);
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if ({busy, done, up_dn, pos, phase_a, phase_b} !== {1'b0, 1'b0, 1'b1, 8'd0, 2'b00}) begin
      errors++;
      $display("FAIL abort_reset got busy=%b done=%b up_dn=%b pos=%0d ab=%b%b, want 0 0 1 0 00",
               busy, done, up_dn, pos, phase_a, phase_b);
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, pos, phase_a, phase_b} !== {1'b0, 1'b0, 8'd0, 2'b00}) begin
        errors++;
        $display("FAIL abort_quiet cyc=%0d got busy=%b done=%b pos=%0d ab=%b%b, want 0 0 0 00",
                 i, busy, done, pos, phase_a, phase_b);
      end
    end
    m_pos = 8'd0; m_ph = 0; m_up = 1'b1;
  endtask

  initial begin
    ph_tab[0] = 2'b00;
    ph_tab[1] = 2'b10;
    ph_tab[2] = 2'b11;
    ph_tab[3] = 2'b01;
    reset = 1'b0; load = 1'b1; data = 8'd0; start = 1'b0;
    target = 8'd0; period = 8'd1; hold = 1'b0;
    m_pos = 8'd0; m_ph = 0; m_up = 1'b1;
    @(negedge clk);
    test_reset();
    test_preset();
    test_up_move();
    test_down_move();
    test_zero_and_ignored();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_mid_move();
    move(8'd3, 8'd1, 0, 0, 1'b0, "post_abort");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
